// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: framebuffer RAM port and game-logic pixel-write port of fb_arbiter.
interface fb_arbiter_if;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [5:0]  mem_wdata;
    logic [5:0]  mem_rdata;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [5:0]  wr_data;
    logic        wr_ack;
    modport master (
        output mem_addr, mem_we, mem_wdata, wr_ack,
        input  mem_rdata, wr_req, wr_addr, wr_data
    );
    modport slave (
        input  mem_addr, mem_we, mem_wdata, wr_ack,
        output mem_rdata, wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one framebuffer RAM port between VGA prefetch, a clear engine and game-logic writes.
// Define FB_CLEAR_EN to build the hardware clear engine.
module fb_arbiter #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int FB_WORDS = FB_W * FB_H
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic [9:0]   x,
    input  logic [9:0]   y,
    input  logic         active,
    output logic [5:0]   RGB,
    input  logic         clear_start,
    input  logic [5:0]   clear_color,
    output logic         clear_busy,
    output logic         frame_done,
    fb_arbiter_if.master bus
);
    localparam logic [9:0]  Y_END = 10'(FB_H * 4);
    localparam logic [9:0]  X_END = 10'(FB_W * 4);
    localparam logic [7:0]  CX_LAST = 8'(FB_W - 1);
    logic [9:0]  x_q, y_q, x_p, y_p;
    logic        vid_pend, rd_q;
    logic [5:0]  pre_reg, pix_reg;
    logic        ls_q, ls_p, il_q, il_p, dp_q, dp_p;
    logic        vid_req, wr_go, wr_ok;
    logic [14:0] line_base, vid_addr, clr_addr;
    logic [5:0]  clr_data;
    // Every trigger fires on the rising edge of its condition between consecutive samples.
    assign ls_q = x_q == 10'h3ff && y_q < Y_END;
    assign ls_p = x_p == 10'h3ff && y_p < Y_END;
    assign il_q = x_q[1:0] == 2'b10 && x_q[9:2] < CX_LAST;
    assign il_p = x_p[1:0] == 2'b10 && x_p[9:2] < CX_LAST;
    assign dp_q = x_q[1:0] == 2'b00 && x_q < X_END;
    assign dp_p = x_p[1:0] == 2'b00 && x_p < X_END;
    assign vid_req = (ls_q && !ls_p) || (il_q && !il_p);
    assign line_base = 15'(y_q[9:2]) * 15'(FB_W);
    assign vid_addr = ls_q ? line_base : line_base + 15'(x_q[9:2]) + 15'd1;
    assign wr_ok = bus.wr_addr < 15'(FB_WORDS);
    assign wr_go = bus.wr_req && !bus.wr_ack && !vid_req && !clear_busy;
    assign frame_done = y_p == Y_END - 10'd1 && y_q >= Y_END;
    assign RGB = (active && y < Y_END) ? pix_reg : 6'd0;
`ifdef FB_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t      state, state_n;
    logic [14:0] cnt, cnt_n;
    logic [5:0]  color, color_n;
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            color <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            color <= color_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        color_n = color;
        if (state == IDLE && clear_start) begin
            state_n = CLEAR;
            cnt_n   = '0;
            color_n = clear_color;
        end else if (state == CLEAR && !vid_req) begin
            cnt_n   = cnt + 15'd1;
            state_n = cnt == 15'(FB_WORDS - 1) ? IDLE : CLEAR;
        end
    end
    assign clear_busy = state == CLEAR;
    assign clr_addr   = cnt;
    assign clr_data   = color;
`else
    logic unused_clear;
    assign unused_clear = ^{clear_start, clear_color};
    assign clear_busy   = 1'b0;
    assign clr_addr     = '0;
    assign clr_data     = '0;
`endif
    // RAM outputs are registered: a grant decided this cycle reaches the RAM next cycle.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            x_q           <= '1;
            y_q           <= '1;
            x_p           <= '1;
            y_p           <= '1;
            vid_pend      <= 1'b0;
            rd_q          <= 1'b0;
            pre_reg       <= '0;
            pix_reg       <= '0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= '0;
            bus.wr_ack    <= 1'b0;
        end else begin
            x_q        <= x;
            y_q        <= y;
            x_p        <= x_q;
            y_p        <= y_q;
            vid_pend   <= vid_req;
            rd_q       <= vid_pend;
            if (rd_q) pre_reg <= bus.mem_rdata;
            if (dp_q && !dp_p) pix_reg <= pre_reg;
            bus.wr_ack <= wr_go;
            bus.mem_we <= !vid_req && (clear_busy || (wr_go && wr_ok));
            if (vid_req) begin
                bus.mem_addr <= vid_addr;
            end else if (clear_busy) begin
                bus.mem_addr  <= clr_addr;
                bus.mem_wdata <= clr_data;
            end else if (wr_go && wr_ok) begin
                bus.mem_addr  <= bus.wr_addr;
                bus.mem_wdata <= bus.wr_data;
            end
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: self-checking bench for fb_arbiter with a RAM model and a framebuffer reference.
module tb_fb_arbiter;
    localparam int W = 160;
    localparam int WORDS = 19200;
    typedef struct packed {
        logic [14:0] addr;
        logic [5:0]  data;
        logic        we;
    } wr_vec_t;
    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] x = 10'd300;
    logic [9:0] y = 10'd100;
    logic       active = 1'b1;
    logic [5:0] rgb;
    logic       clear_start = 1'b0;
    logic [5:0] clear_color = 6'd0;
    logic       clear_busy, frame_done;
    int         checks = 0, errors = 0;
    int         fd_count = 0, n_acks = 0;
    int         wcount = 0, distinct = 0, bad = 0;
    logic       tally = 1'b0, ack_d = 1'b0, stop_wr = 1'b0;
    logic [5:0] ram [WORDS] = '{default: 6'd0};
    logic [5:0] fb_ref [WORDS] = '{default: 6'd0};
    bit         seen [WORDS];
    wr_vec_t    vecs [6];

    fb_arbiter_if bus();

    fb_arbiter dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .x(x), .y(y), .active(active), .RGB(rgb),
        .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
        .frame_done(frame_done), .bus(bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        bus.mem_rdata <= (bus.mem_addr < WORDS) ? ram[bus.mem_addr] : 6'd0;
        if (bus.mem_we && bus.mem_addr < WORDS) ram[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    always @(negedge CLOCK_50) begin
        if (reset && bus.wr_ack) chk("ack_gap", ack_d, 0);
        ack_d = bus.wr_ack;
        if (reset && frame_done) fd_count++;
        if (tally && bus.mem_we) begin
            wcount++;
            if (bus.mem_addr < WORDS && !seen[bus.mem_addr]) begin
                seen[bus.mem_addr] = 1'b1;
                distinct++;
            end
            if (bus.mem_wdata != 6'h3F) bad++;
        end
    end

    initial begin
        #1800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // One scan line: short horizontal blank, then 640 pixels each held for two clocks.
    task automatic scan_line(input int row);
        int cy;
        cy = row / 4;
        x = 10'h3ff;
        y = 10'(row);
        active = 1'b0;
        cyc(1);
        chk("rgb_blank", rgb, 0);
        cyc(1);
        chk("ls_addr", bus.mem_addr, cy * W);
        chk("ls_we", bus.mem_we, 0);
        cyc(6);
        for (int px = 0; px < 640; px++) begin
            x = 10'(px);
            active = 1'b1;
            cyc(1);
            if (px % 4 == 2) chk("rgb", rgb, fb_ref[cy * W + px / 4]);
            cyc(1);
            if (px % 4 == 2 && px / 4 < W - 1) begin
                chk("vf_addr", bus.mem_addr, cy * W + px / 4 + 1);
                chk("vf_we", bus.mem_we, 0);
            end
        end
    endtask

    task automatic pick(output logic [14:0] a, output logic [5:0] d);
        a = ($urandom_range(0, 7) == 0) ? 15'(WORDS + $urandom_range(0, 500)) : 15'(320 + $urandom_range(0, 319));
        d = 6'($urandom);
    endtask

    task automatic rand_writer();
        logic [14:0] a;
        logic [5:0]  d;
        pick(a, d);
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_req = 1'b1;
        while (!stop_wr) begin
            cyc(1);
            if (bus.wr_ack) begin
                n_acks++;
                chk("r_we", bus.mem_we, a < WORDS);
                if (a < WORDS) begin
                    chk("r_addr", bus.mem_addr, a);
                    chk("r_data", bus.mem_wdata, d);
                    fb_ref[a] = d;
                end
                pick(a, d);
                bus.wr_addr = a;
                bus.wr_data = d;
            end
        end
        bus.wr_req = 1'b0;
    endtask

    initial begin
        int n, starve;
        vecs = '{'{15'd161, 6'h2A, 1'b1}, '{15'd0, 6'h01, 1'b1}, '{15'd19199, 6'h15, 1'b1},
                 '{15'd19200, 6'h3F, 1'b0}, '{15'h7FFF, 6'h07, 1'b0}, '{15'd165, 6'h0C, 1'b1}};
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        #5 reset = 1'b0;
        cyc(3);
        chk("rst_rgb", rgb, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_ack", bus.wr_ack, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_fd", frame_done, 0);
        x = 10'h3ff;
        y = 10'h3ff;
        active = 1'b0;
        cyc(1);
        reset = 1'b1;
        n = 0;
        repeat (10) begin
            cyc(1);
            n += bus.mem_we + bus.wr_ack;
        end
        chk("idle_after_rst", n, 0);
        foreach (vecs[i]) begin
            bus.wr_req = 1'b1;
            bus.wr_addr = vecs[i].addr;
            bus.wr_data = vecs[i].data;
            cyc(1);
            chk("t_ack", bus.wr_ack, 1);
            chk("t_we", bus.mem_we, vecs[i].we);
            if (vecs[i].we) begin
                chk("t_addr", bus.mem_addr, vecs[i].addr);
                chk("t_data", bus.mem_wdata, vecs[i].data);
                fb_ref[vecs[i].addr] = vecs[i].data;
            end
            bus.wr_req = 1'b0;
            cyc(1);
            chk("t_ack_pulse", bus.wr_ack, 0);
            chk("t_we_off", bus.mem_we, 0);
        end
        fork
            begin
                for (int r = 0; r < 8; r++) scan_line(r);
                stop_wr = 1'b1;
            end
            rand_writer();
        join
        chk("r_progress", n_acks >= 1000, 1);
        for (int r = 8; r < 16; r++) scan_line(r);
        x = 10'h3ff;
        y = 10'h3ff;
        active = 1'b0;
        cyc(4);
`ifdef FB_CLEAR_EN
        clear_color = 6'h15;
        clear_start = 1'b1;
        cyc(1);
        clear_start = 1'b0;
        cyc(100);
        chk("abort_busy", clear_busy, 1);
        #3 reset = 1'b0;
        #1 chk("abort_rst_busy", clear_busy, 0);
        chk("abort_rst_we", bus.mem_we, 0);
        cyc(2);
        reset = 1'b1;
        n = 0;
        repeat (50) begin
            cyc(1);
            n += bus.mem_we + clear_busy;
        end
        chk("abort_quiet", n, 0);
        chk("busy_idle", clear_busy, 0);
        clear_color = 6'h3F;
        clear_start = 1'b1;
        tally = 1'b1;
        cyc(1);
        clear_start = 1'b0;
        chk("busy_rise", clear_busy, 1);
        bus.wr_req = 1'b1;
        bus.wr_addr = 15'd19200;
        n = 0;
        starve = 0;
        while (clear_busy && n < 25000) begin
            cyc(1);
            n++;
            if (bus.wr_ack) starve++;
            if (n == 10000) begin
                clear_start = 1'b1;
                clear_color = 6'h00;
            end
            if (n == 10001) clear_start = 1'b0;
        end
        chk("clear_done", clear_busy, 0);
        chk("starve", starve, 0);
        cyc(1);
        chk("ack_after_clear", bus.wr_ack, 1);
        chk("oor_no_we", bus.mem_we, 0);
        bus.wr_req = 1'b0;
        cyc(2);
        tally = 1'b0;
        chk("clear_writes", wcount, WORDS);
        chk("clear_cover", distinct, WORDS);
        chk("clear_color", bad, 0);
        foreach (fb_ref[i]) fb_ref[i] = 6'h3F;
`else
        clear_color = 6'h3F;
        clear_start = 1'b1;
        cyc(1);
        clear_start = 1'b0;
        n = 0;
        repeat (20) begin
            cyc(1);
            n += bus.mem_we + clear_busy;
        end
        chk("no_clear", n, 0);
`endif
        for (int r = 0; r < 8; r++) scan_line(r);
        for (int r = 476; r < 480; r++) scan_line(r);
        x = 10'h3ff;
        y = 10'h3ff;
        active = 1'b0;
        cyc(1);
        chk("frame_done", frame_done, 1);
        chk("rgb_vblank", rgb, 0);
        cyc(1);
        chk("frame_done_pulse", frame_done, 0);
        cyc(4);
        chk("fd_count", fd_count, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
